stream_mux2_rr: RTL and testbench

- Two-input stream multiplexer with a registered output and valid/ready handshakes on every port.
- Replaces a static 2:1 select with an internal round-robin arbiter that drives the select each cycle.
- Sits directly upstream of any single-stream consumer; merges two producer streams, sources A and B, into one.
- Reports which source supplied each output beat.

---
 rtl/stream_mux2_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 58 +++++
 rtl/stream_mux2_rr.sv | 103 ++++++++++
 tb/tb_stream_mux2_rr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux2_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux2_pkg
//   Shared types and constants for the two-input round-robin stream mux.
//
//   sel_t        : one-bit source identifier (SEL_A = 0, SEL_B = 1), used for
//                  the out_sel tag and the tie-break priority.
//   GNT_A/GNT_B  : bit positions of each source inside the 2-bit req/grant
//                  vectors exchanged between the top level and the arbiter.
//   other_sel()  : the opposite source; after a source wins, the tie-break
//                  priority moves to the other one.
// -----------------------------------------------------------------------------
package stream_mux2_pkg;

  typedef logic [0:0] sel_t;

  localparam sel_t SEL_A = 1'b0;
  localparam sel_t SEL_B = 1'b1;

  localparam int GNT_A = 0;
  localparam int GNT_B = 1;

  function automatic sel_t other_sel(input sel_t s);
    return (s == SEL_A) ? SEL_B : SEL_A;
  endfunction

endpackage : stream_mux2_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. The grant is combinational. A single
//   priority flop records which requester wins the next tie.
//
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset (priority returns to A)
//   req      in   [GNT_A] = source A requesting, [GNT_B] = source B requesting
//   advance  in   the current grant was consumed this cycle (a transfer)
//   grant    out  one-hot (or zero) grant, same bit layout as req
//   prio     out  requester that wins the next tie
// -----------------------------------------------------------------------------
module rr_arb2
  import stream_mux2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output sel_t       prio
);

  sel_t prio_q;
  sel_t prio_d;

  // A lone requester always wins. On a tie the priority holder wins.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    grant = 2'b00;
    if (req[GNT_A] && req[GNT_B]) begin
      if (prio_q == SEL_A) grant[GNT_A] = 1'b1;
      else                 grant[GNT_B] = 1'b1;
    end else begin
      grant = req;
    end
  end

  // Priority moves only when a grant is actually consumed. A requester that
  // is granted but stalled keeps its claim on the next tie.
  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) begin
      prio_d = grant[GNT_B] ? other_sel(SEL_B) : other_sel(SEL_A);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (rst) prio_q <= SEL_A;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;

endmodule : rr_arb2

// File: rtl/stream_mux2_rr.sv
// -----------------------------------------------------------------------------
// stream_mux2_rr
//   Merges two valid/ready producer streams (A, B) into one registered output
//   stream. A round-robin arbiter picks the source. The output register reloads
//   whenever it is empty or being drained, so a full-rate stream passes with
//   no bubbles.
//
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   a_data     in   source A payload        a_valid in  / a_ready out
//   b_data     in   source B payload        b_valid in  / b_ready out
//   out_data   out  registered payload      out_valid out / out_ready in
//   out_sel    out  source of the current output beat (0 = A, 1 = B)
//   prio       out  source that wins the next tie (0 = A, 1 = B)
//
//   a_ready/b_ready are combinational functions of out_ready and the input
//   valids. The consumer must not route out_ready back from them.
// -----------------------------------------------------------------------------
module stream_mux2_rr
  import stream_mux2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output sel_t             out_sel,
  output sel_t             prio
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  sel_t             out_sel_q,   out_sel_d;

  logic       load_en;
  logic       xfer;
  logic [1:0] req;
  logic [1:0] grant;

  // The register may take a new beat when it is empty or its beat leaves
  // this cycle. Forcing it low in reset keeps both readies low, so a beat
  // offered during reset is never accepted.
  assign load_en = !rst && (!out_valid_q || out_ready);

  assign req[GNT_A] = a_valid;
  assign req[GNT_B] = b_valid;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (xfer),
    .grant   (grant),
    .prio    (prio)
  );

  assign a_ready = load_en && grant[GNT_A];
  assign b_ready = load_en && grant[GNT_B];
  assign xfer    = a_ready || b_ready;

  // On load with no grant the register empties. out_data and out_sel keep
  // their last values, so an idle output still shows the previous beat.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_sel_d  = grant[GNT_B] ? SEL_B : SEL_A;
        out_data_d = grant[GNT_B] ? b_data : a_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SEL_A;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

  // The arbiter grant is one-hot, so at most one source is accepted per cycle.
  a_one_ready : assert property (@(posedge clk) !(a_ready && b_ready));

endmodule : stream_mux2_rr

// File: tb/tb_stream_mux2_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux2_rr
//   Directed scenarios followed by randomized traffic for stream_mux2_rr.
//   Expected values come from constants or from a beat-level reference
//   model. The model tracks the contents of the output slot and the next
//   tie winner, and advances them once per clock.
// -----------------------------------------------------------------------------
module tb_stream_mux2_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:0] out_sel;
  logic [0:0] prio;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the output slot and the next tie winner.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  logic       m_sel   = 1'b0;
  logic       m_prio  = 1'b0;

  stream_mux2_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .prio      (prio)
  );

  always #5 clk = ~clk;

  // Acceptances the rules allow this cycle: {B accepted, A accepted}.
  function automatic logic [1:0] model_ready();
    logic room;
    room = !rst && (!m_valid || out_ready);
    if (!room) return 2'b00;
    if (a_valid && (!b_valid || m_prio == 1'b0)) return 2'b01;
    if (b_valid) return 2'b10;
    return 2'b00;
  endfunction

  // Advance the model using the inputs held across this edge, then move to
  // 1 time unit after the edge so outputs are sampled away from it.
  task automatic tick();
    logic [1:0] r;
    r = model_ready();
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_prio = 1'b0;
    end else if (!m_valid || out_ready) begin
      if (r[0])      begin m_valid = 1'b1; m_data = a_data; m_sel = 1'b0; m_prio = 1'b1; end
      else if (r[1]) begin m_valid = 1'b1; m_data = b_data; m_sel = 1'b1; m_prio = 1'b0; end
      else           m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid); end
      n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready cyc%0d: got %b want 0", c, a_ready); end
      n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready cyc%0d: got %b want 0", c, b_ready); end
      n_cmp++; if (prio !== 1'b0) begin n_err++; $display("FAIL reset_prio cyc%0d: got %b want 0", c, prio); end
    end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    rst = 1'b0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL first_grant_a_ready: got %b want 1", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL first_grant_b_ready: got %b want 0", b_ready); end
    tick();
    n_cmp++; if (out_data !== 8'h11 || out_sel !== 1'b0) begin n_err++; $display("FAIL first_beat: got %h/%b want 11/0", out_data, out_sel); end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL single_data: got %h want 3c", out_data); end
    n_cmp++; if (out_sel !== 1'b0) begin n_err++; $display("FAIL single_sel: got %b want 0", out_sel); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (prio !== 1'b1) begin n_err++; $display("FAIL single_prio: got %b want 1", prio); end
    tick();
  endtask

  task automatic test_contention();
    logic [7:0] exp_data [4];
    int ia, ib;
    logic acc_a;
    exp_data[0] = 8'hA0; exp_data[1] = 8'hB0; exp_data[2] = 8'hA1; exp_data[3] = 8'hB1;
    rst = 1'b1; tick(); rst = 1'b0;
    ia = 0; ib = 0;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      a_data = 8'hA0 + 8'(ia); b_data = 8'hB0 + 8'(ib);
      #1;
      acc_a = a_ready;
      tick();
      if (acc_a) ia++; else ib++;
      n_cmp++; if (out_data !== exp_data[k]) begin n_err++; $display("FAIL contention_data[%0d]: got %h want %h", k, out_data, exp_data[k]); end
      n_cmp++; if (out_sel !== 1'(k % 2)) begin n_err++; $display("FAIL contention_sel[%0d]: got %b want %0d", k, out_sel, k % 2); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    rst = 1'b1; tick(); rst = 1'b0;
    a_valid = 1'b1; a_data = 8'h55; out_ready = 1'b1;
    tick();
    a_valid = 1'b0; out_ready = 1'b0; b_valid = 1'b1; b_data = 8'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL bp_b_ready cyc%0d: got %b want 0", c, b_ready); end
      n_cmp++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold cyc%0d: got %h/%b want 55/1", c, out_data, out_valid); end
      n_cmp++; if (prio !== 1'b1) begin n_err++; $display("FAIL bp_prio cyc%0d: got %b want 1", c, prio); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_b_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h66 || out_sel !== 1'b1) begin n_err++; $display("FAIL bp_b_beat: got %h/%b want 66/1", out_data, out_sel); end
    n_cmp++; if (prio !== 1'b0) begin n_err++; $display("FAIL bp_prio_after: got %b want 0", prio); end
    tick();
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_data = 8'h77; out_ready = 1'b0;
    tick();
    a_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin n_err++; $display("FAIL mid_loaded: got %b/%h want 1/77", out_valid, out_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", out_data); end
    n_cmp++; if (prio !== 1'b0) begin n_err++; $display("FAIL mid_prio: got %b want 0", prio); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_replay cyc%0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_drain();
    b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h5A; out_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid_one: got %b want 1", out_valid); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty cyc%0d: got %b want 0", c, out_valid); end
      n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL drain_retain cyc%0d: got %h want 5a", c, out_data); end
    end
  endtask

  // Random producers hold each beat until it is taken. The consumer stalls
  // at random, and reset is pulsed occasionally.
  task automatic test_random();
    logic [1:0] r;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!a_valid) begin a_valid = 1'($urandom_range(0, 1)); a_data = 8'($urandom); end
      if (!b_valid) begin b_valid = 1'($urandom_range(0, 1)); b_data = 8'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      r = model_ready();
      n_cmp++; if (a_ready !== r[0] || b_ready !== r[1]) begin n_err++; $display("FAIL rand_ready cyc%0d: got a=%b b=%b want a=%b b=%b", c, a_ready, b_ready, r[0], r[1]); end
      tick();
      if (r[0]) a_valid = 1'b0;
      if (r[1]) b_valid = 1'b0;
      n_cmp++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== m_sel || prio !== m_prio) begin
        n_err++;
        $display("FAIL rand_out cyc%0d: got v=%b d=%h s=%b p=%b want v=%b d=%h s=%b p=%b",
                 c, out_valid, out_data, out_sel, prio, m_valid, m_data, m_sel, m_prio);
      end
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_stream_mux2_rr
